// File: rtl/data_sampling_mv_if.sv
// Sampler bus: window/config inputs from the RX edge counter and FSM,
// voted bit and status flags back to the deserializer.
interface data_sampling_mv_if #(
    parameter int PRESCALE_W = 6
);
    logic [PRESCALE_W-1:0] prescale;
    logic [2:0]            num_samples;
    logic                  RX_IN;
    logic                  data_samp_en;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic                  sample_bit;
    logic                  sample_valid;
    logic                  noise_err;
    logic                  cfg_err;

    modport master (
        output prescale, num_samples, RX_IN,
        output data_samp_en, edge_cnt,
        input  sample_bit, sample_valid,
        input  noise_err, cfg_err
    );

    modport slave (
        input  prescale, num_samples, RX_IN,
        input  data_samp_en, edge_cnt,
        output sample_bit, sample_valid,
        output noise_err, cfg_err
    );
endinterface

// File: rtl/data_sampling_mv.sv
// UART RX oversampling sampler: majority vote over an odd number of
// samples centred on the bit middle, with input synchroniser.
module data_sampling_mv #(
    parameter int PRESCALE_W  = 6,
    parameter int MAX_SAMPLES = 7,
    parameter int SYNC_STAGES = 2
) (
    input logic              CLK,
    input logic              RST,
    data_sampling_mv_if.slave bus
);
    typedef logic [PRESCALE_W-1:0] pw_t;

    localparam logic [3:0] MAXN = 4'(MAX_SAMPLES);

    logic rx_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign rx_s = bus.RX_IN;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge CLK) begin
                if (RST) sync_q <= '1;
                else     sync_q <= (sync_q << 1) | SYNC_STAGES'(bus.RX_IN);
            end
            assign rx_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [2:0] sh_n_q, sh_n_d;
    pw_t        sh_pre_q, sh_pre_d;
    logic [2:0] taken_q, taken_d, ones_q, ones_d;
    logic       bit_q, bit_d, valid_q, valid_d;
    logic       noise_q, noise_d, cfg_q;

    function automatic logic [2:0] norm_n(input logic [2:0] req);
        if (req == 3'd0)             return 3'd1;
        else if ({1'b0, req} > MAXN) return MAXN[2:0];
        else if (!req[0])            return req - 3'd1;
        else                         return req;
    endfunction

    logic [2:0] half3;
    pw_t        half, mid_raw, mid, first, last;
    logic [2:0] n_eff;
    logic       cfg_bad;

    // Window from the shadow config; a bad config collapses to one sample.
    always_comb begin
        half3   = (sh_n_q - 3'd1) >> 1;
        half    = pw_t'(half3);
        mid_raw = (sh_pre_q >> 1) - pw_t'(1);
        cfg_bad = (sh_pre_q < pw_t'(2)) || (mid_raw < half);
        mid     = (sh_pre_q < pw_t'(2)) ? '0 : mid_raw;
        first   = cfg_bad ? mid : mid - half;
        last    = cfg_bad ? mid : mid + half;
        n_eff   = cfg_bad ? 3'd1 : sh_n_q;
    end

    logic       samp, dec;
    logic [2:0] taken_tot, ones_tot;

    always_comb begin
        samp = bus.data_samp_en && bus.edge_cnt >= first
            && bus.edge_cnt <= last;
        dec  = bus.data_samp_en && bus.edge_cnt == last;
        // Wrap to edge 0 starts a fresh bit even if the decision was skipped.
        taken_tot = (bus.edge_cnt == '0 ? 3'd0 : taken_q)
                  + {2'b00, samp};
        ones_tot  = (bus.edge_cnt == '0 ? 3'd0 : ones_q)
                  + {2'b00, samp & rx_s};
        taken_d  = taken_tot;
        ones_d   = ones_tot;
        valid_d  = 1'b0;
        bit_d    = bit_q;
        noise_d  = noise_q;
        sh_pre_d = sh_pre_q;
        sh_n_d   = sh_n_q;
        if (!bus.data_samp_en) begin
            taken_d  = '0;
            ones_d   = '0;
            sh_pre_d = bus.prescale;
            sh_n_d   = norm_n(bus.num_samples);
        end else if (dec) begin
            valid_d = 1'b1;
            bit_d   = {ones_tot, 1'b0} > {1'b0, taken_tot};
            noise_d = (taken_tot != n_eff)
                   || (ones_tot != 3'd0 && ones_tot != taken_tot);
            taken_d = '0;
            ones_d  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sh_pre_q <= pw_t'(16);
            sh_n_q   <= 3'd1;
            taken_q  <= '0;
            ones_q   <= '0;
            bit_q    <= 1'b1;
            valid_q  <= 1'b0;
            noise_q  <= 1'b0;
            cfg_q    <= 1'b0;
        end else begin
            sh_pre_q <= sh_pre_d;
            sh_n_q   <= sh_n_d;
            taken_q  <= taken_d;
            ones_q   <= ones_d;
            bit_q    <= bit_d;
            valid_q  <= valid_d;
            noise_q  <= noise_d;
            cfg_q    <= cfg_bad;
        end
    end

    assign bus.sample_bit   = bit_q;
    assign bus.sample_valid = valid_q;
    assign bus.noise_err    = noise_q;
    assign bus.cfg_err      = cfg_q;
endmodule
